// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared types, constants and the round-robin pick function
//                used by the 4-way round-robin arbiter.
//                  N_REQ        - number of requesters (4)
//                  ID_W         - width of a requester index (2)
//                  arb_state_t  - arbiter state: IDLE / GRANT
//                  pick_t       - {found, id} result of a priority search
//                  rr_pick()    - circular search starting at a pointer,
//                                 optionally skipping one index
//  Revision    : 1.0  initial release
// ============================================================================
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic            found;
        logic [ID_W-1:0] id;
    } pick_t;

    // Scans ptr, ptr+1, ... modulo N_REQ and returns the first requesting
    // index. The index arithmetic relies on ID_W-bit wrap-around, so 3+1
    // lands on 0 without an explicit modulo. When excl_en is set, excl_id
    // is never returned even if it is requesting.
    function automatic pick_t rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [ID_W-1:0]  ptr,
        input logic             excl_en,
        input logic [ID_W-1:0]  excl_id
    );
        pick_t           res;
        logic [ID_W-1:0] idx;
        res = '0;
        idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ptr + ID_W'(k);
            if (!res.found && req[idx] && !(excl_en && (idx == excl_id))) begin
                res.found = 1'b1;
                res.id    = idx;
            end
        end
        return res;
    endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/decoder_2x4.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_2x4
//  Description : 2-to-4 one-hot decoder with enable.
//  Ports       : en    in  1  enable; output is all-zero when low
//                addr  in  2  index of the bit to assert
//                y     out 4  one-hot output
//  Revision    : 1.0  initial release
// ============================================================================
module decoder_2x4 (
    input  logic       en,
    input  logic [1:0] addr,
    output logic [3:0] y
);

    always_comb begin
        y = 4'b0000;
        if (en) begin
            y[addr] = 1'b1;
        end
    end

endmodule : decoder_2x4
`default_nettype wire

// File: rtl/rr_arbiter_4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_4
//  Description : Round-robin arbiter sharing one resource among 4 requesters.
//                The winner index and a valid flag are registered; the
//                one-hot grant is decoded combinationally from them. An owner
//                keeps the grant while it requests, but after MAX_HOLD
//                consecutive cycles it is rotated away if anyone else waits.
//  Parameters  : MAX_HOLD   max consecutive grant cycles while others wait
//                           (legal range 2..256)
//  Ports       : clk        in  1  rising-edge clock
//                rst_n      in  1  asynchronous active-low reset
//                en         in  1  enable; low releases grant, no new grants
//                req        in  4  level request vector
//                gnt        out 4  one-hot grant, 0000 when gnt_valid=0
//                gnt_id     out 2  index of current owner
//                gnt_valid  out 1  a grant is active
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid
);

    localparam int              HOLD_W   = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    arb_state_t        r_state;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_gnt_id;
    logic              r_gnt_valid;
    logic [HOLD_W-1:0] r_hold_cnt;

    arb_state_t        w_state_nxt;
    logic [ID_W-1:0]   w_ptr_nxt;
    logic [ID_W-1:0]   w_gnt_id_nxt;
    logic              w_gnt_valid_nxt;
    logic [HOLD_W-1:0] w_hold_cnt_nxt;

    // ------------------------------------------------------------------
    // Search results
    //   w_pick_open : plain search from ptr (new grant / release handover)
    //   w_pick_excl : search from ptr skipping the current owner (rotation)
    // ------------------------------------------------------------------
    pick_t             w_pick_open;
    pick_t             w_pick_excl;
    logic              w_owner_req;
    logic              w_hold_last;
    logic              w_others_req;

    assign w_pick_open  = rr_pick(req, r_ptr, 1'b0, r_gnt_id);
    assign w_pick_excl  = rr_pick(req, r_ptr, 1'b1, r_gnt_id);
    assign w_owner_req  = req[r_gnt_id];
    assign w_hold_last  = (r_hold_cnt == HOLD_LAST);
    assign w_others_req = |(req & ~(N_REQ'(1) << r_gnt_id));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_gnt_id_nxt    = r_gnt_id;
        w_gnt_valid_nxt = r_gnt_valid;
        w_hold_cnt_nxt  = r_hold_cnt;

        case (r_state)
            IDLE: begin
                if (en && w_pick_open.found) begin
                    w_state_nxt     = GRANT;
                    w_gnt_id_nxt    = w_pick_open.id;
                    w_gnt_valid_nxt = 1'b1;
                    w_hold_cnt_nxt  = '0;
                    w_ptr_nxt       = w_pick_open.id + ID_W'(1);
                end
            end

            GRANT: begin
                if (!en) begin
                    // Disable wins over everything; ptr is kept so the next
                    // enable resumes the rotation where it stopped.
                    w_state_nxt     = IDLE;
                    w_gnt_valid_nxt = 1'b0;
                end else if (!w_owner_req) begin
                    // Owner released: hand over on this same edge so there
                    // is no dead cycle between owners.
                    if (w_pick_open.found) begin
                        w_gnt_id_nxt   = w_pick_open.id;
                        w_hold_cnt_nxt = '0;
                        w_ptr_nxt      = w_pick_open.id + ID_W'(1);
                    end else begin
                        w_state_nxt     = IDLE;
                        w_gnt_valid_nxt = 1'b0;
                    end
                end else if (w_hold_last && w_others_req) begin
                    // Hold budget spent and someone else is waiting: the
                    // excluded search is guaranteed to find them.
                    w_gnt_id_nxt   = w_pick_excl.id;
                    w_hold_cnt_nxt = '0;
                    w_ptr_nxt      = w_pick_excl.id + ID_W'(1);
                end else if (w_hold_last) begin
                    // Sole requester: keep the grant, restart the budget.
                    w_hold_cnt_nxt = '0;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end

            default: begin
                w_state_nxt     = IDLE;
                w_gnt_valid_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_hold_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: gnt depends only on registers, so an asynchronous reset
    // clears it immediately.
    // ------------------------------------------------------------------
    decoder_2x4 u_gnt_dec (
        .en   (r_gnt_valid),
        .addr (r_gnt_id),
        .y    (gnt)
    );

    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;

endmodule : rr_arbiter_4
`default_nettype wire

// File: tb/tb_rr_arbiter_4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter_4
//  Description : Self-checking bench for rr_arbiter_4 (MAX_HOLD=4). A
//                behavioural model tracks owner, rotation pointer and the
//                number of cycles the owner has held the grant.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rr_arbiter_4;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;

    int n_pass;
    int n_total;

    // Reference model state
    bit m_valid;
    int m_owner;
    int m_ptr;
    int m_held;   // cycles the current owner has held the grant (1 on grant)

    rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Model
    // ------------------------------------------------------------------
    function automatic int pick(input logic [3:0] r, input int from, input int excl);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (from + k) % 4;
            if (r[idx] && idx != excl) return idx;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_gnt();
        return m_valid ? (4'b0001 << m_owner) : 4'b0000;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_owner = 0;
        m_ptr   = 0;
        m_held  = 0;
    endtask

    task automatic model_grant(input int w);
        m_valid = 1;
        m_owner = w;
        m_held  = 1;
        m_ptr   = (w + 1) % 4;
    endtask

    task automatic model_step(input logic e, input logic [3:0] r);
        int w;
        if (!m_valid) begin
            if (e && r != 4'b0000) model_grant(pick(r, m_ptr, -1));
        end else if (!e) begin
            m_valid = 0;
        end else if (!r[m_owner]) begin
            w = pick(r, m_ptr, -1);
            if (w < 0) m_valid = 0;
            else       model_grant(w);
        end else if (m_held == MAX_HOLD) begin
            w = pick(r, m_ptr, m_owner);
            if (w >= 0) model_grant(w);
            else        m_held = 1;
        end else begin
            m_held++;
        end
    endtask

    // Drive inputs, advance one edge, update the model, sample 1 time unit later.
    task automatic tick(input logic e, input logic [3:0] r);
        en  = e;
        req = r;
        @(posedge clk);
        model_step(e, r);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 4'b0000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        req   = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_total++;
            if (gnt !== 4'b0000 || gnt_valid !== 1'b0)
                $display("FAIL reset_hold: gnt=%b valid=%b, required gnt=0000 valid=0", gnt, gnt_valid);
            else n_pass++;
        end
        rst_n = 1'b1;
        model_reset();
        tick(1'b1, 4'b1111);
        n_total++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0 || gnt_valid !== 1'b1)
            $display("FAIL reset_first_grant: gnt=%b id=%0d valid=%b, required 0001/0/1", gnt, gnt_id, gnt_valid);
        else n_pass++;
    endtask

    task automatic test_rotation();
        logic [3:0] exp;
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            tick(1'b1, 4'b1111);
            exp = 4'b0001 << ((i / MAX_HOLD) % 4);
            n_total++;
            if (gnt !== exp || gnt !== m_gnt())
                $display("FAIL rotation[%0d]: gnt=%b, required %b (model %b)", i, gnt, exp, m_gnt());
            else n_pass++;
        end
    endtask

    task automatic test_release_no_gap();
        apply_reset();
        tick(1'b1, 4'b0001);
        tick(1'b1, 4'b0001);
        tick(1'b1, 4'b0100);
        n_total++;
        if (gnt !== 4'b0100 || gnt_valid !== 1'b1 || gnt_id !== 2'd2)
            $display("FAIL release_handover: gnt=%b valid=%b id=%0d, required 0100/1/2", gnt, gnt_valid, gnt_id);
        else n_pass++;
        // ptr is now 3: when owner 2 releases with 0 and 3 requesting, 3 wins.
        tick(1'b1, 4'b1001);
        n_total++;
        if (gnt !== 4'b1000 || gnt !== m_gnt())
            $display("FAIL release_ptr: gnt=%b, required 1000 (model %b)", gnt, m_gnt());
        else n_pass++;
    endtask

    task automatic test_sole_requester();
        int bad;
        apply_reset();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 4'b0010);
            if (gnt !== 4'b0010 || gnt_valid !== 1'b1) bad++;
        end
        n_total++;
        if (bad != 0)
            $display("FAIL sole_requester: %0d cycles without gnt=0010 valid=1, required 0", bad);
        else n_pass++;
    endtask

    task automatic test_en_toggle();
        apply_reset();
        tick(1'b1, 4'b1111);
        tick(1'b0, 4'b1111);
        n_total++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0)
            $display("FAIL en_off: gnt=%b valid=%b, required 0000/0", gnt, gnt_valid);
        else n_pass++;
        tick(1'b1, 4'b1111);
        n_total++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1)
            $display("FAIL en_regrant: gnt=%b id=%0d, required 0010/1", gnt, gnt_id);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        tick(1'b1, 4'b0100);
        n_total++;
        if (gnt !== 4'b0100)
            $display("FAIL async_pre: gnt=%b, required 0100", gnt);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0)
            $display("FAIL async_drop: gnt=%b valid=%b, required 0000/0", gnt, gnt_valid);
        else n_pass++;
        #2;
        rst_n = 1'b1;
        model_reset();
        tick(1'b1, 4'b1111);
        n_total++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0)
            $display("FAIL async_ptr_reset: gnt=%b id=%0d, required 0001/0", gnt, gnt_id);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic       e;
        apply_reset();
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            // Requests mostly persist as levels, occasionally change.
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            e = ($urandom_range(0, 9) != 0);
            tick(e, r);
            n_total++;
            if (gnt !== m_gnt() || gnt_valid !== m_valid ||
                (m_valid && gnt_id !== 2'(m_owner)))
                $display("FAIL random[%0d]: gnt=%b valid=%b id=%0d, required gnt=%b valid=%b id=%0d",
                         i, gnt, gnt_valid, gnt_id, m_gnt(), m_valid, m_owner);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        en      = 1'b0;
        req     = 4'b0000;
        model_reset();
        test_reset();
        test_rotation();
        test_release_no_gap();
        test_sole_requester();
        test_en_toggle();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_rr_arbiter_4
`default_nettype wire
